// File: rtl/bp_pkg.sv
// Shared types and constants for the gshare branch predictor.
// Counter encodings, BTB entry layout and predictor FSM states.
package bp_pkg;

  typedef logic [1:0] cnt_t;

  localparam cnt_t SNT = 2'b00;
  localparam cnt_t WNT = 2'b01;
  localparam cnt_t WT  = 2'b10;
  localparam cnt_t ST  = 2'b11;
  localparam cnt_t CNT_INIT = WNT;

  typedef enum logic {
    BR_BRANCH = 1'b0,
    BR_JUMP   = 1'b1
  } br_type_e;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_e;

  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
    br_type_e    btype;
  } btb_entry_t;

  function automatic logic [29:0] bp_tag(
    logic [31:0] pc,
    int          bits
  );
    return 30'(pc >> (bits + 2));
  endfunction

endpackage

// File: rtl/bp_sat_cnt.sv
// Next-state function of a 2-bit saturating
// direction counter.
module bp_sat_cnt (
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] nxt
);
  import bp_pkg::*;

  always_comb begin
    nxt = cnt;
    unique case (1'b1)
      taken && (cnt != ST):
        nxt = cnt + 2'd1;
      !taken && (cnt != SNT):
        nxt = cnt - 2'd1;
      default:
        nxt = cnt;
    endcase
  end

endmodule

// File: rtl/gshare_bp.sv
// Gshare direction predictor with tagged BTB,
// speculative history and execute-time recovery.
module gshare_bp #(
  parameter int         GHR_BITS = 10,
  parameter int         PHT_BITS = 10,
  parameter int         BTB_BITS = 8,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [31:0]         i_pc_F,
  input  logic                i_stall_F,
  output logic                o_pc_sel,
  output logic [31:0]         o_pc_target_F,
  output logic [GHR_BITS-1:0] o_ghr_F,
  input  logic                i_br_en_E,
  input  logic                i_jump_en_E,
  input  logic [31:0]         i_pc_E,
  input  logic                i_taken_E,
  input  logic [31:0]         i_target_E,
  input  logic [GHR_BITS-1:0] i_ghr_E,
  input  logic                i_pred_taken_E,
  input  logic [31:0]         i_pred_target_E,
  output logic                o_pc_rp_sel,
  output logic [31:0]         o_pc_rp,
  output logic                o_rst_br_F,
  output logic                o_ready
);
  import bp_pkg::*;

  localparam int PHT_N = 1 << PHT_BITS;
  localparam int BTB_N = 1 << BTB_BITS;
  localparam int SW_BITS =
    (PHT_BITS > BTB_BITS) ? PHT_BITS : BTB_BITS;

  cnt_t       pht [PHT_N];
  btb_entry_t btb [BTB_N];

  bp_state_e           state;
  logic [SW_BITS-1:0]  sweep;
  logic [GHR_BITS-1:0] ghr;
  logic                rp_sel;
  logic [31:0]         rp;

  logic                run;
  logic [PHT_BITS-1:0] pidx;
  logic [PHT_BITS-1:0] pidx_e;
  logic [BTB_BITS-1:0] bidx;
  logic [BTB_BITS-1:0] bidx_e;
  btb_entry_t          ent;
  cnt_t                cnt_f;
  cnt_t                cnt_e;
  cnt_t                cnt_nxt;
  logic                hit;
  logic                pred;
  logic                mis;
  logic                btb_we;
  logic                redir;
  logic [31:0]         redir_pc;
  logic                unused;

  assign run    = (state == RUN);
  assign pidx   = i_pc_F[PHT_BITS+1:2]
                ^ PHT_BITS'(ghr);
  assign bidx   = i_pc_F[BTB_BITS+1:2];
  assign ent    = btb[bidx];
  assign cnt_f  = pht[pidx];
  assign pred   = cnt_f[1];
  assign hit    = ent.valid
               && (ent.tag == bp_tag(i_pc_F, BTB_BITS));
  assign unused = cnt_f[0];

  assign o_pc_sel      = run && hit && pred;
  assign o_pc_target_F = run ? ent.target : '0;
  assign o_ghr_F       = ghr;
  assign o_ready       = run;
  assign o_pc_rp_sel   = rp_sel;
  assign o_rst_br_F    = rp_sel;
  assign o_pc_rp       = rp;

  assign pidx_e = i_pc_E[PHT_BITS+1:2]
                ^ PHT_BITS'(i_ghr_E);
  assign bidx_e = i_pc_E[BTB_BITS+1:2];
  assign cnt_e  = pht[pidx_e];

  bp_sat_cnt u_cnt (
    .cnt   (cnt_e),
    .taken (i_taken_E),
    .nxt   (cnt_nxt)
  );

  assign mis = i_br_en_E
    && ((i_taken_E != i_pred_taken_E)
     || (i_taken_E
      && (i_target_E != i_pred_target_E)));

  // Branch wins over a (flagged) simultaneous jump.
  assign btb_we = i_br_en_E ? i_taken_E : i_jump_en_E;

  always_comb begin
    redir    = 1'b0;
    redir_pc = '0;
    if (i_br_en_E) begin
      redir = mis;
      if (mis)
        redir_pc = i_taken_E ? i_target_E
                             : i_pc_E + 32'd4;
    end else if (i_jump_en_E
      && (!i_pred_taken_E
       || (i_pred_target_E != i_target_E))) begin
      redir    = 1'b1;
      redir_pc = i_target_E;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= INIT;
      sweep  <= '0;
      ghr    <= '0;
      rp_sel <= 1'b0;
      rp     <= '0;
    end else begin
      rp_sel <= redir;
      rp     <= redir_pc;
      if (state == INIT) begin
        sweep <= sweep + 1'b1;
        if (&sweep)
          state <= RUN;
      end
      if (mis)
        ghr <= {i_ghr_E[GHR_BITS-2:0], i_taken_E};
      else if (run && !i_stall_F && hit
            && (ent.btype == BR_BRANCH))
        ghr <= {ghr[GHR_BITS-2:0], pred};
    end
  end

  // Tables are cleared by the sweep, not by reset.
  always_ff @(posedge i_clk) begin
    if (!run)
      pht[sweep[PHT_BITS-1:0]] <= CNT_INIT;
    else if (i_br_en_E)
      pht[pidx_e] <= cnt_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (!run)
      btb[sweep[BTB_BITS-1:0]] <= btb_entry_t'('0);
    else if (btb_we)
      btb[bidx_e] <= '{
        valid:  1'b1,
        tag:    bp_tag(i_pc_E, BTB_BITS),
        target: i_target_E,
        btype:  i_br_en_E ? BR_BRANCH : BR_JUMP
      };
  end

  a_one_hot_e: assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    !(i_br_en_E && i_jump_en_E));

endmodule

// File: tb/tb_gshare_bp.sv
// Directed bench for gshare_bp with a table-level
// reference model compared on every falling edge.
module tb_gshare_bp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_pc_F = 32'h1000;
  logic        i_stall_F = 1'b0;
  logic        o_pc_sel;
  logic [31:0] o_pc_target_F;
  logic [9:0]  o_ghr_F;
  logic        i_br_en_E = 1'b0;
  logic        i_jump_en_E = 1'b0;
  logic [31:0] i_pc_E = '0;
  logic        i_taken_E = 1'b0;
  logic [31:0] i_target_E = '0;
  logic [9:0]  i_ghr_E = '0;
  logic        i_pred_taken_E = 1'b0;
  logic [31:0] i_pred_target_E = '0;
  logic        o_pc_rp_sel;
  logic [31:0] o_pc_rp;
  logic        o_rst_br_F;
  logic        o_ready;

  int n_cmp = 0;
  int n_bad = 0;

  gshare_bp dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_pc_F          (i_pc_F),
    .i_stall_F       (i_stall_F),
    .o_pc_sel        (o_pc_sel),
    .o_pc_target_F   (o_pc_target_F),
    .o_ghr_F         (o_ghr_F),
    .i_br_en_E       (i_br_en_E),
    .i_jump_en_E     (i_jump_en_E),
    .i_pc_E          (i_pc_E),
    .i_taken_E       (i_taken_E),
    .i_target_E      (i_target_E),
    .i_ghr_E         (i_ghr_E),
    .i_pred_taken_E  (i_pred_taken_E),
    .i_pred_target_E (i_pred_target_E),
    .o_pc_rp_sel     (o_pc_rp_sel),
    .o_pc_rp         (o_pc_rp),
    .o_rst_br_F      (o_rst_br_F),
    .o_ready         (o_ready)
  );

  always #5 clk = ~clk;

  task automatic check(string name,
                       logic [31:0] act,
                       logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h @%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: plain arrays of table contents.
  int          m_pht [1024];
  bit          m_v   [256];
  int unsigned m_tag [256];
  int unsigned m_tgt [256];
  bit          m_jmp [256];
  bit          m_run = 0;
  int          m_sweep = 0;
  int unsigned m_ghr = 0;
  bit          m_rp_sel = 0;
  int unsigned m_rp = 0;

  function automatic int bi(logic [31:0] pc);
    return int'((pc >> 2) & 32'd255);
  endfunction

  function automatic int pi(logic [31:0] pc,
                            int unsigned g);
    return int'(((pc >> 2) & 32'd1023) ^ g);
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    return m_v[bi(pc)]
        && (m_tag[bi(pc)] == (pc >> 10));
  endfunction

  function automatic bit m_pred(logic [31:0] pc);
    return m_pht[pi(pc, m_ghr)] >= 2;
  endfunction

  function automatic bit m_sel();
    return m_run && m_hit(i_pc_F) && m_pred(i_pc_F);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_sweep = 0; m_ghr = 0;
      m_rp_sel = 0; m_rp = 0;
    end else begin
      bit          rd;
      int unsigned rpc;
      int unsigned ng;
      int          pe;
      int          be;
      rd = 0; rpc = 0; ng = m_ghr;
      pe = pi(i_pc_E, i_ghr_E);
      be = bi(i_pc_E);
      if (m_run && !i_stall_F && m_hit(i_pc_F)
          && !m_jmp[bi(i_pc_F)])
        ng = ((m_ghr << 1) | m_pred(i_pc_F)) & 1023;
      if (i_br_en_E) begin
        if (i_taken_E != i_pred_taken_E
            || (i_taken_E
             && i_target_E != i_pred_target_E)) begin
          rd = 1;
          rpc = i_taken_E ? i_target_E : i_pc_E + 4;
          ng = ((i_ghr_E << 1) | i_taken_E) & 1023;
        end
        if (m_run) begin
          if (i_taken_E && m_pht[pe] < 3)
            m_pht[pe]++;
          if (!i_taken_E && m_pht[pe] > 0)
            m_pht[pe]--;
          if (i_taken_E) begin
            m_v[be] = 1; m_tag[be] = i_pc_E >> 10;
            m_tgt[be] = i_target_E; m_jmp[be] = 0;
          end
        end
      end else if (i_jump_en_E) begin
        if (m_run) begin
          m_v[be] = 1; m_tag[be] = i_pc_E >> 10;
          m_tgt[be] = i_target_E; m_jmp[be] = 1;
        end
        if (!i_pred_taken_E
            || i_pred_target_E != i_target_E) begin
          rd = 1; rpc = i_target_E;
        end
      end
      m_ghr = ng; m_rp_sel = rd; m_rp = rpc;
      if (!m_run) begin
        m_sweep++;
        if (m_sweep == 1024) begin
          m_run = 1;
          foreach (m_pht[i]) m_pht[i] = 1;
          foreach (m_v[i]) m_v[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit es;
    es = m_sel();
    check("pc_sel", o_pc_sel, es);
    if (es)
      check("pc_target", o_pc_target_F,
            m_tgt[bi(i_pc_F)]);
    check("ghr", o_ghr_F, m_ghr);
    check("ready", o_ready, m_run);
    check("rp_sel", o_pc_rp_sel, m_rp_sel);
    check("rst_br", o_rst_br_F, m_rp_sel);
    check("rp", o_pc_rp, m_rp);
  end

  task automatic exec_br(logic [31:0] pc, logic tk,
                         logic [31:0] tg, logic [9:0] gh,
                         logic pt, logic [31:0] ptg);
    i_br_en_E = 1; i_pc_E = pc; i_taken_E = tk;
    i_target_E = tg; i_ghr_E = gh;
    i_pred_taken_E = pt; i_pred_target_E = ptg;
    @(posedge clk); #1;
    i_br_en_E = 0;
  endtask

  task automatic exec_jmp(logic [31:0] pc,
                          logic [31:0] tg, logic pt,
                          logic [31:0] ptg);
    i_jump_en_E = 1; i_pc_E = pc; i_target_E = tg;
    i_pred_taken_E = pt; i_pred_target_E = ptg;
    @(posedge clk); #1;
    i_jump_en_E = 0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!o_ready && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_latency", n, 1024);
  endtask

  logic [31:0] v_pcf [8] = '{32'h300, 32'h300,
    32'h100, 32'h500, 32'h300, 32'h300,
    32'h40, 32'h300};
  logic        v_tk  [8] = '{1, 1, 0, 1, 0, 0, 1, 1};
  logic        v_pt  [8] = '{0, 1, 0, 1, 1, 0, 0, 1};

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    i_pc_F = 32'h100;
    wait_ready();
    i_pc_F = 32'h1000;

    // Cold taken branch, history at its fixed point.
    exec_br(32'h100, 1, 32'h200, 10'h3FF, 0, 0);
    check("br1_rp_sel", o_pc_rp_sel, 1);
    check("br1_rp", o_pc_rp, 32'h200);
    check("br1_ghr", o_ghr_F, 10'h3FF);
    exec_br(32'h100, 1, 32'h200, 10'h3FF, 0, 0);
    check("br2_rp", o_pc_rp, 32'h200);
    i_pc_F = 32'h100;
    #2;
    check("br2_pred", o_pc_sel, 1);
    check("br2_target", o_pc_target_F, 32'h200);
    @(posedge clk); #1;
    check("br2_rp_clear", o_pc_rp_sel, 0);

    // Not taken vs prediction, restore beats shift.
    exec_br(32'h100, 0, 32'h200, 10'h3FF, 1, 32'h200);
    check("nt_rp", o_pc_rp, 32'h104);
    check("nt_ghr", o_ghr_F, 10'h3FE);
    i_stall_F = 1;
    exec_br(32'h2000, 1, 32'h3000, 10'h3FF, 0, 0);
    check("g_ghr", o_ghr_F, 10'h3FF);
    #2;
    check("nt_cnt_wt", o_pc_sel, 1);

    // Jump cold then correctly predicted.
    exec_jmp(32'h40, 32'h80, 0, 0);
    check("jal_rp", o_pc_rp, 32'h80);
    exec_jmp(32'h40, 32'h80, 1, 32'h80);
    check("jal_no_rp", o_pc_rp_sel, 0);
    check("jal_ghr", o_ghr_F, 10'h3FF);

    // Aliasing eviction.
    exec_br(32'h500, 1, 32'h600, 10'h0, 0, 0);
    check("alias_ghr", o_ghr_F, 10'h001);
    #2;
    check("alias_miss", o_pc_sel, 0);

    // PC+4 wraps.
    exec_br(32'hFFFF_FFFC, 0, 32'h10, 10'h0, 1, 32'h10);
    check("wrap_sel", o_pc_rp_sel, 1);
    check("wrap_rp", o_pc_rp, 32'h0);

    i_stall_F = 0;
    for (int i = 0; i < 8; i++) begin
      i_pc_F = v_pcf[i];
      exec_br(32'h300, v_tk[i], 32'h340,
              10'(i * 37), v_pt[i], 32'h340);
      @(posedge clk); #1;
    end

    // Mid-run reset and re-sweep.
    rst_n = 0;
    #2;
    check("rst_ready", o_ready, 0);
    check("rst_ghr", o_ghr_F, 10'h0);
    check("rst_rp", o_pc_rp_sel, 0);
    @(posedge clk); #1;
    rst_n = 1;
    i_pc_F = 32'h100;
    wait_ready();
    #2;
    check("resweep_miss", o_pc_sel, 0);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
